// File: rtl/lvds_cnt_pattern_gen.sv
// lvds_cnt_pattern_gen: serial LVDS counting-frame source (preamble, 2'b11 header, 16-bit count, gaps).
// Define LVDS_GEN_ERR_INJ_EN to add err_inject, which arms a one-shot +2 sequence break.
module lvds_cnt_pattern_gen #(
    parameter int          PREAMBLE_LEN = 32,
    parameter int          FRAME_GAP    = 4,
    parameter int          NUM_FRAMES   = 256,
    parameter logic [15:0] START_VALUE  = 16'h0000
) (
    input  logic        clk,
    input  logic        syst_rst_n,
    input  logic        user_ena,
`ifdef LVDS_GEN_ERR_INJ_EN
    input  logic        err_inject,
`endif
    output logic        out_lvds,
    output logic        busy,
    output logic        done,
    output logic [15:0] frame_cnt,
    output logic [15:0] cur_value
);
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_PAY, S_GAP, S_DONE} state_t;

    localparam int MAXPG = PREAMBLE_LEN > FRAME_GAP ? PREAMBLE_LEN : FRAME_GAP;
    localparam int MAXL  = MAXPG > 16 ? MAXPG : 16;
    localparam int CW    = $clog2(MAXL + 1);

    state_t          r_state, w_nxt;
    logic [CW-1:0]   r_cnt, w_nxt_cnt;
    logic            r_drain, w_drain;
    logic            w_last, w_arm;
    logic [15:0]     w_step;

    always_comb begin
        w_nxt   = r_state;
        w_drain = r_drain;
        w_last  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_drain = 1'b0;
                if (user_ena) w_nxt = S_PRE;
            end
            S_PRE: begin
                if (!user_ena) w_nxt = S_IDLE;
                else if (r_cnt == CW'(PREAMBLE_LEN - 1)) w_nxt = S_HDR;
            end
            S_HDR: begin
                w_drain = r_drain | !user_ena;
                if (r_cnt == CW'(1)) w_nxt = S_PAY;
            end
            S_PAY: begin
                w_drain = r_drain | !user_ena;
                if (r_cnt == CW'(15)) begin
                    w_nxt  = S_GAP;
                    w_last = 1'b1;
                end
            end
            S_GAP: begin
                // a drop seen during the frame lets the gap finish; a drop in the gap aborts at once
                if (!r_drain && !user_ena) w_nxt = S_IDLE;
                else if (r_cnt == CW'(FRAME_GAP - 1))
                    w_nxt = r_drain ? S_IDLE :
                            (NUM_FRAMES != 0 && frame_cnt == 16'(NUM_FRAMES)) ? S_DONE : S_HDR;
            end
            S_DONE: begin
                if (!user_ena) w_nxt = S_IDLE;
            end
            default: w_nxt = S_IDLE;
        endcase
        w_nxt_cnt = (w_nxt == r_state) ? r_cnt + 1'b1 : '0;
    end

`ifdef LVDS_GEN_ERR_INJ_EN
    logic r_arm;
    assign w_arm = r_arm | (err_inject && r_state != S_DONE);
    always_ff @(posedge clk) begin
        if (!syst_rst_n) r_arm <= 1'b0;
        else             r_arm <= w_last ? 1'b0 : w_arm;
    end
`else
    assign w_arm = 1'b0;
`endif

    assign w_step = w_arm ? 16'd2 : 16'd1;

    always_ff @(posedge clk) begin
        if (!syst_rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_drain   <= 1'b0;
            out_lvds  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_cnt <= 16'h0000;
            cur_value <= START_VALUE;
        end else begin
            r_state  <= w_nxt;
            r_cnt    <= w_nxt_cnt;
            r_drain  <= w_drain;
            busy     <= w_nxt inside {S_PRE, S_HDR, S_PAY, S_GAP};
            done     <= w_nxt == S_DONE;
            out_lvds <= (w_nxt == S_HDR) || (w_nxt == S_PAY && cur_value[4'd15 - w_nxt_cnt[3:0]]);
            if (r_state == S_IDLE && user_ena) begin
                cur_value <= START_VALUE;
                frame_cnt <= 16'h0000;
            end
            if (w_last) begin
                cur_value <= cur_value + w_step;
                frame_cnt <= frame_cnt + {15'd0, frame_cnt != 16'hFFFF};
            end
        end
    end
endmodule

// File: tb/tb_lvds_cnt_pattern_gen.sv
// tb_lvds_cnt_pattern_gen: line-stream reference model plus spot-check table for lvds_cnt_pattern_gen.
module tb_lvds_cnt_pattern_gen;
    localparam int          PL   = 32;
    localparam int          FG   = 4;
    localparam int          FP   = 18 + FG;
    localparam int          A_NF = 256;
    localparam logic [15:0] A_SV = 16'h0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena_a = 1'b0;
    logic ena_b = 1'b0;
    logic a_out, a_busy, a_done, b_out, b_busy, b_done;
    logic [15:0] a_fc, a_cv, b_fc, b_cv;
`ifdef LVDS_GEN_ERR_INJ_EN
    logic err_a = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int g_skip  = -1;

    logic        rb_out  [200];
    logic        rb_busy [200];
    logic        rb_done [200];
    logic [15:0] rb_fc   [200];
    logic [15:0] rb_cv   [200];

    typedef struct packed {
        logic [7:0]  p;
        logic        o, bz, dn;
        logic [15:0] fc, cv;
    } vec_t;
    vec_t tbl [13];

    always #5 clk = ~clk;

    lvds_cnt_pattern_gen #(.PREAMBLE_LEN(PL), .FRAME_GAP(FG), .NUM_FRAMES(A_NF), .START_VALUE(A_SV)) dut_a (
        .clk(clk), .syst_rst_n(rst_n), .user_ena(ena_a),
`ifdef LVDS_GEN_ERR_INJ_EN
        .err_inject(err_a),
`endif
        .out_lvds(a_out), .busy(a_busy), .done(a_done), .frame_cnt(a_fc), .cur_value(a_cv));

    lvds_cnt_pattern_gen #(.PREAMBLE_LEN(PL), .FRAME_GAP(FG), .NUM_FRAMES(4), .START_VALUE(16'hFFFE)) dut_b (
        .clk(clk), .syst_rst_n(rst_n), .user_ena(ena_b),
`ifdef LVDS_GEN_ERR_INJ_EN
        .err_inject(1'b0),
`endif
        .out_lvds(b_out), .busy(b_busy), .done(b_done), .frame_cnt(b_fc), .cur_value(b_cv));

    task automatic chk(input string nm, input int p, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @pos %0d: got %0h want %0h", nm, p, got, exp);
        end
    endtask

    // payload of frame f; a planted break adds one to every frame after g_skip
    function automatic logic [15:0] val_m(input int f);
        return 16'(A_SV + f + ((g_skip >= 0 && f > g_skip) ? 1 : 0));
    endfunction

    // frames whose last payload bit was on the line before position p
    function automatic int fc_m(input int p);
        int n;
        if (p - PL - 17 <= 0) return 0;
        n = (p - PL + 4) / FP;
        return n > A_NF ? A_NF : n;
    endfunction

    function automatic logic bit_m(input int p);
        int q, f, r;
        logic [15:0] v;
        if (p < PL) return 1'b0;
        q = p - PL;
        f = q / FP;
        r = q % FP;
        if (f >= A_NF) return 1'b0;
        if (r < 2) return 1'b1;
        if (r >= 18) return 1'b0;
        v = val_m(f);
        return v[17-r];
    endfunction

    function automatic int idle_pos(input int d);
        if (d < PL) return d + 1;
        return ((d - PL) % FP >= 18) ? d + 1 : PL + ((d - PL) / FP + 1) * FP;
    endfunction

    // ena_a must already be high; position 0 is the first preamble bit
    task automatic run_a(input int n, input int drop, input int inj);
        int stop;
        stop = drop >= 0 ? idle_pos(drop) : 32'h7fffffff;
        for (int p = 0; p < n; p++) begin
            @(negedge clk);
`ifdef LVDS_GEN_ERR_INJ_EN
            err_a = (p == inj);
`endif
            if (p < stop) begin
                chk("line", p, 32'(a_out), 32'(bit_m(p)));
                chk("busy", p, 32'(a_busy), 32'(p < PL + A_NF * FP));
                chk("done", p, 32'(a_done), 32'(p >= PL + A_NF * FP));
                chk("frame_cnt", p, 32'(a_fc), 32'(fc_m(p)));
                chk("cur_value", p, 32'(a_cv), 32'(val_m(fc_m(p))));
            end else begin
                chk("idle_line", p, 32'(a_out), 32'd0);
                chk("idle_busy", p, 32'(a_busy), 32'd0);
                chk("idle_done", p, 32'(a_done), 32'd0);
                chk("idle_fc", p, 32'(a_fc), 32'(fc_m(stop)));
                chk("idle_cv", p, 32'(a_cv), 32'(val_m(fc_m(stop))));
            end
            if (p < 200) begin
                rb_out[p] = b_out; rb_busy[p] = b_busy; rb_done[p] = b_done;
                rb_fc[p] = b_fc;   rb_cv[p] = b_cv;
            end
            if (p == drop) ena_a = 1'b0;
        end
    endtask

    initial begin
        tbl[0]  = '{8'd0,   1'b0, 1'b1, 1'b0, 16'd0, 16'hFFFE};
        tbl[1]  = '{8'd31,  1'b0, 1'b1, 1'b0, 16'd0, 16'hFFFE};
        tbl[2]  = '{8'd32,  1'b1, 1'b1, 1'b0, 16'd0, 16'hFFFE};
        tbl[3]  = '{8'd34,  1'b1, 1'b1, 1'b0, 16'd0, 16'hFFFE};
        tbl[4]  = '{8'd49,  1'b0, 1'b1, 1'b0, 16'd0, 16'hFFFE};
        tbl[5]  = '{8'd50,  1'b0, 1'b1, 1'b0, 16'd1, 16'hFFFF};
        tbl[6]  = '{8'd71,  1'b1, 1'b1, 1'b0, 16'd1, 16'hFFFF};
        tbl[7]  = '{8'd78,  1'b0, 1'b1, 1'b0, 16'd2, 16'h0000};
        tbl[8]  = '{8'd115, 1'b1, 1'b1, 1'b0, 16'd3, 16'h0001};
        tbl[9]  = '{8'd116, 1'b0, 1'b1, 1'b0, 16'd4, 16'h0002};
        tbl[10] = '{8'd119, 1'b0, 1'b1, 1'b0, 16'd4, 16'h0002};
        tbl[11] = '{8'd120, 1'b0, 1'b0, 1'b1, 16'd4, 16'h0002};
        tbl[12] = '{8'd125, 1'b0, 1'b0, 1'b1, 16'd4, 16'h0002};

        ena_a = 1'b1;
        ena_b = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_line_a", 0, 32'(a_out), 32'd0);
        chk("rst_busy_a", 0, 32'(a_busy), 32'd0);
        chk("rst_done_a", 0, 32'(a_done), 32'd0);
        chk("rst_fc_a", 0, 32'(a_fc), 32'd0);
        chk("rst_cv_a", 0, 32'(a_cv), 32'(A_SV));
        chk("rst_cv_b", 0, 32'(b_cv), 32'h0000FFFE);
        chk("rst_busy_b", 0, 32'(b_busy), 32'd0);
        rst_n = 1'b1;

        run_a(PL + A_NF * FP + 5, -1, -1);
        for (int i = 0; i < 13; i++) begin
            chk("b_line", int'(tbl[i].p), 32'(rb_out[tbl[i].p]), 32'(tbl[i].o));
            chk("b_busy", int'(tbl[i].p), 32'(rb_busy[tbl[i].p]), 32'(tbl[i].bz));
            chk("b_done", int'(tbl[i].p), 32'(rb_done[tbl[i].p]), 32'(tbl[i].dn));
            chk("b_fc", int'(tbl[i].p), 32'(rb_fc[tbl[i].p]), 32'(tbl[i].fc));
            chk("b_cv", int'(tbl[i].p), 32'(rb_cv[tbl[i].p]), 32'(tbl[i].cv));
        end

        ena_a = 1'b0;
        ena_b = 1'b0;
        @(negedge clk);
        chk("done_exit_a", 0, 32'(a_done), 32'd0);
        chk("done_exit_busy_a", 0, 32'(a_busy), 32'd0);
        chk("done_exit_fc_a", 0, 32'(a_fc), 32'd256);
        chk("done_exit_b", 0, 32'(b_done), 32'd0);

        ena_a = 1'b1;
        run_a(PL + 3 * FP + 4, PL + 2 * FP + 2 + 4, -1);
        ena_a = 1'b1;
        run_a(PL + FP + 18, -1, -1);

        rst_n = 1'b0;
        ena_a = 1'b0;
        @(negedge clk);
        chk("midrst_line", 0, 32'(a_out), 32'd0);
        chk("midrst_busy", 0, 32'(a_busy), 32'd0);
        chk("midrst_done", 0, 32'(a_done), 32'd0);
        chk("midrst_fc", 0, 32'(a_fc), 32'd0);
        chk("midrst_cv", 0, 32'(a_cv), 32'(A_SV));
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_busy", 0, 32'(a_busy), 32'd0);

        for (int t = 0; t < 8; t++) begin
            int d;
            d = int'($urandom_range(0, PL + 5 * FP - 1));
            ena_a = 1'b1;
            run_a(idle_pos(d) + 3, d, -1);
        end

`ifdef LVDS_GEN_ERR_INJ_EN
        g_skip = 9;
        ena_a = 1'b1;
        run_a(PL + 13 * FP + 22, PL + 13 * FP + 19, PL + 9 * FP + 5);
        g_skip = -1;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
